serial_slave_burst: RTL and testbench

//  Next-generation serial bus slave: bit-serial control/read/write to a local synchronous RAM.

---
 rtl/serial_slave_burst.sv | 191 +++++++++++++++++++
 tb/tb_serial_slave_burst.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_slave_burst.sv
// serial_slave_burst: bit-serial bus slave doing single/burst reads and writes
// to a local RAM. In: clk, rst (async high), control, wD, valid, last.
// Out: rD (serial read data), ready, busy (not IDLE), err (bad address pulse).
module serial_slave_burst #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_DEPTH = 16,
  parameter int SLAVES     = 3,
  parameter int SLAVE_ID   = 1,
  parameter int MAX_BURST  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic control,
  input  logic wD,
  input  logic valid,
  input  logic last,
  output logic rD,
  output logic ready,
  output logic busy,
  output logic err
);
  localparam int AW      = $clog2(ADDR_DEPTH);
  localparam int IDW     = $clog2(SLAVES + 1);
  localparam int CFG_LEN = 5 + IDW + AW;
  localparam int CCW     = $clog2(CFG_LEN + 1);
  localparam int BCW     = $clog2(DATA_WIDTH + 1);
  localparam int WCW     = $clog2(MAX_BURST + 1);

  typedef enum logic [2:0] {
    IDLE, CFG, DECODE, RD_FETCH, RD_SHIFT, WR_SHIFT, WR_COMMIT
  } state_t;

  state_t                state_q, state_d;
  logic [CFG_LEN-1:0]    cfg_q, cfg_d;
  logic [CCW-1:0]        ccnt_q, ccnt_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic                  burst_q, burst_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [BCW-1:0]        bcnt_q, bcnt_d;
  logic [WCW-1:0]        wcnt_q, wcnt_d;
  logic                  lseen_q, lseen_d;
  logic                  we;
  logic [DATA_WIDTH-1:0] mem [ADDR_DEPTH];

  logic [2:0]     f_start;
  logic [IDW-1:0] f_id;
  logic           f_rw;
  logic           f_burst;
  logic [AW-1:0]  f_addr;
  logic           hit;
  logic           more_ok;
  logic           bit_end;
  logic [AW-1:0]  addr_nxt;

  assign f_start = cfg_q[CFG_LEN-1 -: 3];
  assign f_id    = cfg_q[CFG_LEN-4 -: IDW];
  assign f_rw    = cfg_q[AW+1];
  assign f_burst = cfg_q[AW];
  assign f_addr  = cfg_q[AW-1:0];

  assign hit      = (f_start == 3'b111) && (32'(f_id) == SLAVE_ID);
  assign more_ok  = burst_q && (32'(wcnt_q) + 1 < MAX_BURST);
  assign bit_end  = (32'(bcnt_q) == DATA_WIDTH - 1);
  assign addr_nxt = (32'(addr_q) == ADDR_DEPTH - 1) ? '0 : addr_q + 1'b1;
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    ccnt_d  = ccnt_q;
    addr_d  = addr_q;
    burst_d = burst_q;
    sh_d    = sh_q;
    bcnt_d  = bcnt_q;
    wcnt_d  = wcnt_q;
    lseen_d = lseen_q;
    rD      = 1'b0;
    ready   = 1'b1;
    err     = 1'b0;
    we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (control) begin
          cfg_d   = {cfg_q[CFG_LEN-2:0], 1'b1};
          ccnt_d  = CCW'(1);
          state_d = CFG;
        end
      end
      CFG: begin
        cfg_d  = {cfg_q[CFG_LEN-2:0], control};
        ccnt_d = ccnt_q + 1'b1;
        if (32'(ccnt_q) == CFG_LEN - 1) begin
          ccnt_d  = '0;
          state_d = DECODE;
        end
      end
      DECODE: begin
        // a frame for someone else leaves us looking idle
        ready   = !hit;
        state_d = IDLE;
        if (hit && (32'(f_addr) >= ADDR_DEPTH)) begin
          err = 1'b1;
        end else if (hit) begin
          addr_d  = f_addr;
          burst_d = f_burst;
          wcnt_d  = '0;
          bcnt_d  = '0;
          lseen_d = 1'b0;
          state_d = f_rw ? WR_SHIFT : RD_FETCH;
        end
      end
      RD_FETCH: begin
        ready   = 1'b0;
        sh_d    = mem[addr_q];
        bcnt_d  = '0;
        lseen_d = 1'b0;
        state_d = RD_SHIFT;
      end
      RD_SHIFT: begin
        rD      = sh_q[DATA_WIDTH-1];
        sh_d    = sh_q << 1;
        bcnt_d  = bcnt_q + 1'b1;
        lseen_d = lseen_q | last;
        if (bit_end) begin
          if (more_ok && !(lseen_q || last)) begin
            addr_d  = addr_nxt;
            wcnt_d  = wcnt_q + 1'b1;
            state_d = RD_FETCH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      WR_SHIFT: begin
        if (valid) begin
          sh_d   = {sh_q[DATA_WIDTH-2:0], wD};
          bcnt_d = bcnt_q + 1'b1;
          if (bit_end) begin
            lseen_d = last;
            bcnt_d  = '0;
            state_d = WR_COMMIT;
          end
        end
      end
      WR_COMMIT: begin
        ready = 1'b0;
        we    = 1'b1;
        if (more_ok && !lseen_q) begin
          addr_d  = addr_nxt;
          wcnt_d  = wcnt_q + 1'b1;
          bcnt_d  = '0;
          state_d = WR_SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      ccnt_q  <= '0;
      addr_q  <= '0;
      burst_q <= 1'b0;
      sh_q    <= '0;
      bcnt_q  <= '0;
      wcnt_q  <= '0;
      lseen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      ccnt_q  <= ccnt_d;
      addr_q  <= addr_d;
      burst_q <= burst_d;
      sh_q    <= sh_d;
      bcnt_q  <= bcnt_d;
      wcnt_q  <= wcnt_d;
      lseen_q <= lseen_d;
    end
  end

  // RAM is not reset; writes only happen from WR_COMMIT, which reset leaves
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      mem[addr_q] <= sh_q;
    end
  end
endmodule

// File: tb/tb_serial_slave_burst.sv
// tb_serial_slave_burst: randomized scoreboard bench for serial_slave_burst.
// A second instance with ADDR_DEPTH=15 exercises the out-of-range err pulse.
module tb_serial_slave_burst;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int MAXB  = 4;
  localparam int CFGL  = 11;

  logic clk = 1'b0;
  logic rst, control, wD, valid, last;
  logic rD, ready, busy, err;
  logic rD2, ready2, busy2, err2;

  int total = 0;
  int bad = 0;
  int exp_err2 = 0;
  int got_err2 = 0;
  int got_err1 = 0;

  logic [7:0] ram_m [DEPTH];
  logic [7:0] wdat [4];
  logic [7:0] rd_q [$];

  always #5 clk = ~clk;

  serial_slave_burst dut (
    .clk(clk), .rst(rst), .control(control), .wD(wD),
    .valid(valid), .last(last), .rD(rD), .ready(ready),
    .busy(busy), .err(err)
  );

  serial_slave_burst #(.ADDR_DEPTH(15)) dut2 (
    .clk(clk), .rst(rst), .control(control), .wD(wD),
    .valid(valid), .last(last), .rD(rD2), .ready(ready2),
    .busy(busy2), .err(err2)
  );

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // monitor: collects each read word after a ready-low gap, checks vs queue
  logic [7:0] mword = '0;
  int mnb = 0;
  bit gap = 1'b0;
  bit err2_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      gap = 1'b0;
      mnb = 0;
      err2_prev = 1'b0;
    end else begin
      if (err) got_err1++;
      if (err2) begin
        got_err2++;
        check("err2_width", {31'd0, err2_prev}, 0);
      end
      err2_prev = err2;
      if (!busy) begin
        check("rd_idle_zero", {31'd0, rD}, 0);
        if (mnb != 0) check("partial_word", mnb, 0);
        gap = 1'b0;
        mnb = 0;
      end else if (!ready) begin
        if (mnb != 0) check("partial_word", mnb, 0);
        gap = 1'b1;
        mnb = 0;
      end else if (gap && rd_q.size() > 0) begin
        mword = {mword[6:0], rD};
        mnb++;
        if (mnb == DW) begin
          check("rd_word", {24'd0, mword}, {24'd0, rd_q.pop_front()});
          mnb = 0;
          gap = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [2:0] st, input logic [1:0] id,
                            input logic rw, input logic bu,
                            input logic [3:0] a);
    logic [CFGL-1:0] f;
    f = {st, id, rw, bu, a};
    for (int k = CFGL - 1; k >= 0; k--) begin
      control = f[k];
      tick();
    end
    control = 1'b0;
  endtask

  task automatic wait_idle(inout int cyc);
    int g;
    g = 0;
    while (busy && g < 100) begin
      tick();
      cyc++;
      g++;
    end
    if (busy) check("idle_timeout", {31'd0, busy}, 0);
  endtask

  function automatic int nwords(input bit bu, input int lastw);
    if (!bu) return 1;
    return (lastw + 1 < MAXB) ? lastw + 1 : MAXB;
  endfunction

  task automatic do_write(input logic [3:0] a, input bit bu, input int lastw,
                          input int sbit, input int slen);
    int n, cyc, g, stalls;
    n = nwords(bu, lastw);
    for (int i = 0; i < n; i++) ram_m[(a + i) % DEPTH] = wdat[i];
    if (a == 4'd15) exp_err2++;
    send_frame(3'b111, 2'd1, 1'b1, bu, a);
    check("wr_decode_ready", {31'd0, ready}, 0);
    cyc = 0;
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      g = 0;
      while (!ready && g < 8) begin
        tick();
        cyc++;
        g++;
      end
      for (int b = 0; b < DW; b++) begin
        if (i == 0 && b == sbit) begin
          for (int s = 0; s < slen; s++) begin
            valid = 1'b0;
            wD = 1'($urandom_range(0, 1));
            tick();
            cyc++;
            stalls++;
            check("stall_ready", {31'd0, ready}, 1);
          end
        end
        valid = 1'b1;
        wD = wdat[i][7-b];
        if (b == DW - 1 && bu) last = (i == lastw);
        else last = 1'($urandom_range(0, 1));
        tick();
        cyc++;
      end
    end
    valid = 1'b0;
    last = 1'b0;
    wD = 1'b0;
    wait_idle(cyc);
    check("wr_cycles", cyc, 1 + 9 * n + stalls);
    check("err2_count", got_err2, exp_err2);
  endtask

  task automatic do_read(input logic [3:0] a, input bit bu, input int lastw,
                         input int lbit);
    int n, cyc, g;
    n = nwords(bu, lastw);
    for (int i = 0; i < n; i++) rd_q.push_back(ram_m[(a + i) % DEPTH]);
    if (a == 4'd15) exp_err2++;
    send_frame(3'b111, 2'd1, 1'b0, bu, a);
    check("rd_decode_ready", {31'd0, ready}, 0);
    cyc = 0;
    for (int i = 0; i < n; i++) begin
      g = 0;
      while (!ready && g < 8) begin
        tick();
        cyc++;
        g++;
      end
      for (int b = 0; b < DW; b++) begin
        last = (i == lastw) && (b == lbit);
        tick();
        cyc++;
      end
    end
    last = 1'b0;
    wait_idle(cyc);
    check("rd_cycles", cyc, 1 + 9 * n);
    check("rd_q_empty", rd_q.size(), 0);
    rd_q.delete();
    check("err2_count", got_err2, exp_err2);
  endtask

  task automatic bad_frame(input logic [2:0] st, input logic [1:0] id,
                           input logic [3:0] a);
    int cyc;
    send_frame(st, id, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a);
    check("bad_ready", {31'd0, ready}, 1);
    cyc = 0;
    wait_idle(cyc);
    check("bad_cycles", cyc, 1);
    check("err2_count", got_err2, exp_err2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] a;
    int op, lw;
    rst = 1'b1;
    control = 1'b0;
    wD = 1'b0;
    valid = 1'b0;
    last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rD", {31'd0, rD}, 0);
    check("rst_ready", {31'd0, ready}, 1);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_err", {31'd0, err}, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < DEPTH; i++) begin
      wdat[0] = 8'($urandom);
      do_write(4'(i), 1'b0, 0, 8, 0);
    end

    wdat[0] = 8'hA5;
    do_write(4'd3, 1'b0, 0, 8, 0);
    do_read(4'd3, 1'b0, 99, 0);

    wdat[0] = 8'hA1;
    wdat[1] = 8'hB2;
    wdat[2] = 8'hC3;
    do_write(4'd14, 1'b1, 2, 8, 0);
    do_read(4'd14, 1'b1, 2, 3);

    do_read(4'd0, 1'b1, 99, 0);

    wdat[0] = 8'h5A;
    do_write(4'd9, 1'b0, 0, 4, 5);
    do_read(4'd9, 1'b0, 99, 0);

    bad_frame(3'b111, 2'd2, 4'd3);
    bad_frame(3'b110, 2'd1, 4'd3);
    do_read(4'd3, 1'b0, 99, 0);
    do_read(4'd15, 1'b0, 99, 0);

    send_frame(3'b111, 2'd1, 1'b1, 1'b0, 4'd6);
    tick();
    for (int b = 0; b < 4; b++) begin
      valid = 1'b1;
      wD = ~ram_m[6][7-b];
      tick();
    end
    rst = 1'b1;
    #1;
    check("midrst_rD", {31'd0, rD}, 0);
    check("midrst_ready", {31'd0, ready}, 1);
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_err", {31'd0, err}, 0);
    valid = 1'b0;
    wD = 1'b0;
    #2;
    rst = 1'b0;
    tick();
    do_read(4'd6, 1'b0, 99, 0);

    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 4);
      a = 4'($urandom_range(0, 15));
      lw = $urandom_range(0, 5);
      for (int w = 0; w < 4; w++) wdat[w] = 8'($urandom);
      case (op)
        0: do_write(a, 1'b0, 0, $urandom_range(1, 7), $urandom_range(0, 4));
        1: do_write(a, 1'b1, lw, $urandom_range(1, 7), $urandom_range(0, 3));
        2: do_read(a, 1'b0, lw, $urandom_range(0, 7));
        3: do_read(a, 1'b1, lw, $urandom_range(0, 7));
        default: begin
          if ($urandom_range(0, 1) == 1)
            bad_frame(3'b111, 2'($urandom_range(2, 3)), a);
          else
            bad_frame(3'($urandom_range(4, 6)), 2'd1, a);
        end
      endcase
    end

    check("dut_err_never", got_err1, 0);
    check("dut2_busy_end", {31'd0, busy2}, 0);
    check("dut2_ready_end", {31'd0, ready2}, 1);
    check("dut2_rd_end", {31'd0, rD2}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
